// File: rtl/sdram_req_queue.sv
// rtl/sdram_req_queue.sv - SoC request FIFO and one-at-a-time issue sequencer for sdram_controller
//
// Queues SoC read/write requests in a DEPTH-entry FIFO. Requests are issued one at
// a time over the controller soc_side_* handshake. Read data comes back to the SoC
// as a one-cycle response pulse.
// Optional feature macro: SDRAM_REQ_QUEUE_TIMEOUT_EN adds a WAIT-state watchdog that
// gives up after TIMEOUT_CYCLES and returns an error response.
//
// Ports:
//   clk, reset_n_port             clock, asynchronous active-low reset
//   req_valid/ready/we/addr/wdata/wmask_port
//                                 SoC request push side (ready = FIFO not full)
//   rsp_valid/rdata/err_port      one-cycle read response (err only with watchdog)
//   fifo_level_port               current FIFO occupancy
//   ctrl_busy/ready/rd_data_port  controller status and read data
//   ctrl_addr/wr_data/wr_mask/wr_en/rd_en_port
//                                 registered command to the controller
module sdram_req_queue #(
  parameter int ADDR_WIDTH     = 23,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset_n_port,
  input  logic                    req_valid_port,
  output logic                    req_ready_port,
  input  logic                    req_we_port,
  input  logic [ADDR_WIDTH-1:0]   req_addr_port,
  input  logic [31:0]             req_wdata_port,
  input  logic [3:0]              req_wmask_port,
  output logic                    rsp_valid_port,
  output logic [31:0]             rsp_rdata_port,
  output logic                    rsp_err_port,
  output logic [$clog2(DEPTH):0]  fifo_level_port,
  input  logic                    ctrl_busy_port,
  input  logic                    ctrl_ready_port,
  output logic [ADDR_WIDTH-1:0]   ctrl_addr_port,
  output logic [31:0]             ctrl_wr_data_port,
  output logic [3:0]              ctrl_wr_mask_port,
  output logic                    ctrl_wr_en_port,
  output logic                    ctrl_rd_en_port,
  input  logic [31:0]             ctrl_rd_data_port
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_WIDTH + 32 + 4;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic [EW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic                  is_read_q, is_read_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  full, empty, push, pop;
  logic [EW-1:0]         head;

`ifdef SDRAM_REQ_QUEUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen during the last allowed WAIT cycle.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  // No bypass: a pop in the same cycle does not reopen a full FIFO.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = req_valid_port && !full;
  assign head  = mem_q[rd_ptr_q];

  assign req_ready_port    = !full;
  assign fifo_level_port   = count_q;
  assign ctrl_addr_port    = addr_q;
  assign ctrl_wr_data_port = wdata_q;
  assign ctrl_wr_mask_port = wmask_q;
  assign ctrl_wr_en_port   = wr_en_q;
  assign ctrl_rd_en_port   = rd_en_q;
  assign rsp_valid_port    = rsp_valid_q;
  assign rsp_rdata_port    = rsp_rdata_q;
`ifdef SDRAM_REQ_QUEUE_TIMEOUT_EN
  assign rsp_err_port      = rsp_err_q;
`else
  assign rsp_err_port      = 1'b0;
`endif

  // Storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_we_port, req_addr_port, req_wdata_port, req_wmask_port};
    end
  end

  always_ff @(posedge clk or negedge reset_n_port) begin
    if (!reset_n_port) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      is_read_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef SDRAM_REQ_QUEUE_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      is_read_q   <= is_read_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef SDRAM_REQ_QUEUE_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    is_read_d   = is_read_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
`ifdef SDRAM_REQ_QUEUE_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    rsp_err_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!empty && !ctrl_busy_port) begin
          pop       = 1'b1;
          is_read_d = !head[EW-1];
          addr_d    = head[EW-2 -: ADDR_WIDTH];
          wdata_d   = head[35:4];
          wmask_d   = head[3:0];
          wr_en_d   = head[EW-1];
          rd_en_d   = !head[EW-1];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef SDRAM_REQ_QUEUE_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (ctrl_ready_port) begin
          state_d = S_IDLE;
          if (is_read_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ctrl_rd_data_port;
          end
        end
`ifdef SDRAM_REQ_QUEUE_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          // Give up on the controller; a ready arriving later lands in IDLE and is ignored.
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

endmodule

// File: tb/tb_sdram_req_queue.sv
// tb/tb_sdram_req_queue.sv - self-checking bench for sdram_req_queue
module tb_sdram_req_queue;

  localparam int AW = 23;
  localparam int IW = 2 + AW + 36;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_wmask = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [2:0]    fifo_level;
  logic          ctrl_busy = 1'b0;
  logic          ctrl_ready = 1'b0;
  logic [AW-1:0] ctrl_addr;
  logic [31:0]   ctrl_wr_data;
  logic [3:0]    ctrl_wr_mask;
  logic          ctrl_wr_en;
  logic          ctrl_rd_en;
  logic [31:0]   ctrl_rd_data = 32'hBAD0BAD0;

  int            n_checks = 0;
  int            n_fail = 0;
  int            model_lat = 3;
  logic [31:0]   model_rdata = 32'h13579BDF;

  // Scoreboard: expected entries pushed with stimulus, observed entries from monitors.
  logic [IW-1:0] exp_issue_q[$];
  logic [IW-1:0] obs_issue_q[$];
  logic [32:0]   exp_rsp_q[$];
  logic [32:0]   obs_rsp_q[$];
  logic [IW-1:0] ei, oi;
  logic [32:0]   er, orr;

  sdram_req_queue #(.ADDR_WIDTH(AW), .DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .reset_n_port      (reset_n),
    .req_valid_port    (req_valid),
    .req_ready_port    (req_ready),
    .req_we_port       (req_we),
    .req_addr_port     (req_addr),
    .req_wdata_port    (req_wdata),
    .req_wmask_port    (req_wmask),
    .rsp_valid_port    (rsp_valid),
    .rsp_rdata_port    (rsp_rdata),
    .rsp_err_port      (rsp_err),
    .fifo_level_port   (fifo_level),
    .ctrl_busy_port    (ctrl_busy),
    .ctrl_ready_port   (ctrl_ready),
    .ctrl_addr_port    (ctrl_addr),
    .ctrl_wr_data_port (ctrl_wr_data),
    .ctrl_wr_mask_port (ctrl_wr_mask),
    .ctrl_wr_en_port   (ctrl_wr_en),
    .ctrl_rd_en_port   (ctrl_rd_en),
    .ctrl_rd_data_port (ctrl_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk_issue(input logic we, input logic [AW-1:0] a,
                                             input logic [31:0] d, input logic [3:0] m);
    return {!we, we, a, d, m};
  endfunction

  // Controller model: ready pulse model_lat cycles after seeing an enable.
  always begin
    @(negedge clk);
    if (ctrl_wr_en || ctrl_rd_en) begin
      repeat (model_lat) @(negedge clk);
      ctrl_ready   = 1'b1;
      ctrl_rd_data = model_rdata;
      @(negedge clk);
      ctrl_ready   = 1'b0;
      ctrl_rd_data = 32'hBAD0BAD0;
    end
  end

  always @(negedge clk) begin
    if (ctrl_wr_en || ctrl_rd_en)
      obs_issue_q.push_back({ctrl_rd_en, ctrl_wr_en, ctrl_addr, ctrl_wr_data, ctrl_wr_mask});
    if (rsp_valid)
      obs_rsp_q.push_back({rsp_err, rsp_rdata});
  end

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push_req(input logic we, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] m);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_wait: req_ready %b after 100 cycles, required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ready_level: ready %b level %0d, required 1 and 0", req_ready, fifo_level);
    end
    n_checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, ctrl_addr, ctrl_wr_data, ctrl_wr_mask, ctrl_wr_en, ctrl_rd_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rsp %b/%h/%b ctrl %h/%h/%b/%b/%b, required all 0",
               rsp_valid, rsp_rdata, rsp_err, ctrl_addr, ctrl_wr_data, ctrl_wr_mask, ctrl_wr_en, ctrl_rd_en);
    end
    model_lat = 3; model_rdata = 32'h13579BDF;
    exp_issue_q.push_back(mk_issue(1'b0, 23'h000123, 32'h0, 4'h0));
    exp_rsp_q.push_back({1'b0, 32'h13579BDF});
    req_valid = 1'b1; req_we = 1'b0; req_addr = 23'h000123; req_wdata = '0; req_wmask = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (fifo_level !== 3'd1 || ctrl_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL first_push: level %0d rd_en %b, required 1 and 0", fifo_level, ctrl_rd_en);
    end
    @(negedge clk);
    n_checks++;
    if (ctrl_rd_en !== 1'b1 || ctrl_wr_en !== 1'b0 || ctrl_addr !== 23'h000123 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL first_issue: rd_en %b wr_en %b addr %h level %0d, required 1 0 000123 0",
               ctrl_rd_en, ctrl_wr_en, ctrl_addr, fifo_level);
    end
    @(negedge clk);
    n_checks++;
    if (ctrl_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL first_pulse_width: rd_en %b one cycle later, required 0", ctrl_rd_en);
    end
    repeat (12) @(negedge clk);
    #1;
    while (exp_issue_q.size() > 0) begin
      ei = exp_issue_q.pop_front();
      oi = (obs_issue_q.size() > 0) ? obs_issue_q.pop_front() : '0;
      n_checks++;
      if (oi !== ei) begin n_fail++; $display("FAIL reset_read_issue: got %h, required %h", oi, ei); end
    end
    while (exp_rsp_q.size() > 0) begin
      er = exp_rsp_q.pop_front();
      orr = (obs_rsp_q.size() > 0) ? obs_rsp_q.pop_front() : '0;
      n_checks++;
      if (orr !== er) begin n_fail++; $display("FAIL reset_read_rsp: got %h, required %h", orr, er); end
    end
    n_checks++;
    if (obs_issue_q.size() != 0 || obs_rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_read_extra: %0d issues %0d responses left, required 0 0", obs_issue_q.size(), obs_rsp_q.size());
    end
    obs_issue_q.delete(); obs_rsp_q.delete();
  endtask

  task automatic test_write;
    model_lat = 5;
    exp_issue_q.push_back(mk_issue(1'b1, 23'h7FFFFF, 32'hDEADBEEF, 4'b0010));
    push_req(1'b1, 23'h7FFFFF, 32'hDEADBEEF, 4'b0010);
    repeat (20) @(negedge clk);
    #1;
    while (exp_issue_q.size() > 0) begin
      ei = exp_issue_q.pop_front();
      oi = (obs_issue_q.size() > 0) ? obs_issue_q.pop_front() : '0;
      n_checks++;
      if (oi !== ei) begin n_fail++; $display("FAIL write_issue: got %h, required %h", oi, ei); end
    end
    n_checks++;
    if (obs_issue_q.size() != 0 || obs_rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL write_silent: %0d extra issues %0d responses, required 0 0", obs_issue_q.size(), obs_rsp_q.size());
    end
    obs_issue_q.delete(); obs_rsp_q.delete();
  endtask

  task automatic test_read_latency;
    int i;
    model_lat = 20; model_rdata = 32'hCAFEF00D;
    exp_issue_q.push_back(mk_issue(1'b0, 23'h001234, 32'h0, 4'h0));
    exp_rsp_q.push_back({1'b0, 32'hCAFEF00D});
    push_req(1'b0, 23'h001234, 32'h0, 4'h0);
    for (i = 0; i < 60; i++) begin
      @(posedge clk);
      if (ctrl_ready) break;
    end
    n_checks++;
    if (i >= 60) begin n_fail++; $display("FAIL read_ready_wait: ctrl_ready never seen, required within 60 cycles"); end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL read_rsp_timing: valid %b rdata %h, required 1 cafef00d", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_rsp_width: valid %b, required 0", rsp_valid); end
    repeat (3) @(negedge clk);
    #1;
    while (exp_issue_q.size() > 0) begin
      ei = exp_issue_q.pop_front();
      oi = (obs_issue_q.size() > 0) ? obs_issue_q.pop_front() : '0;
      n_checks++;
      if (oi !== ei) begin n_fail++; $display("FAIL read_issue: got %h, required %h", oi, ei); end
    end
    while (exp_rsp_q.size() > 0) begin
      er = exp_rsp_q.pop_front();
      orr = (obs_rsp_q.size() > 0) ? obs_rsp_q.pop_front() : '0;
      n_checks++;
      if (orr !== er) begin n_fail++; $display("FAIL read_rsp: got %h, required %h", orr, er); end
    end
    n_checks++;
    if (obs_issue_q.size() != 0 || obs_rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_extra: %0d issues %0d responses left, required 0 0", obs_issue_q.size(), obs_rsp_q.size());
    end
    obs_issue_q.delete(); obs_rsp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic          we_t [5];
    logic [AW-1:0] a_t  [5];
    model_lat = 2; model_rdata = 32'h55AA33CC;
    we_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    a_t  = '{23'h000010, 23'h000020, 23'h000030, 23'h000040, 23'h000050};
    for (int k = 0; k < 5; k++) begin
      exp_issue_q.push_back(mk_issue(we_t[k], a_t[k], 32'hA000_0000 + k, 4'(k)));
      if (!we_t[k]) exp_rsp_q.push_back({1'b0, 32'h55AA33CC});
    end
    ctrl_busy = 1'b1;
    for (int k = 0; k < 4; k++) push_req(we_t[k], a_t[k], 32'hA000_0000 + k, 4'(k));
    n_checks++;
    if (fifo_level !== 3'd4 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: level %0d ready %b, required 4 0", fifo_level, req_ready);
    end
    fork
      push_req(we_t[4], a_t[4], 32'hA000_0004, 4'd4);
      begin
        repeat (5) @(negedge clk);
        n_checks++;
        if (fifo_level !== 3'd4 || req_ready !== 1'b0 || ctrl_rd_en !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_stall: level %0d ready %b rd_en %b, required 4 0 0", fifo_level, req_ready, ctrl_rd_en);
        end
        ctrl_busy = 1'b0;
      end
    join
    repeat (60) @(negedge clk);
    #1;
    n_checks++;
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL drain_level: level %0d, required 0", fifo_level); end
    while (exp_issue_q.size() > 0) begin
      ei = exp_issue_q.pop_front();
      oi = (obs_issue_q.size() > 0) ? obs_issue_q.pop_front() : '0;
      n_checks++;
      if (oi !== ei) begin n_fail++; $display("FAIL order_issue: got %h, required %h", oi, ei); end
    end
    while (exp_rsp_q.size() > 0) begin
      er = exp_rsp_q.pop_front();
      orr = (obs_rsp_q.size() > 0) ? obs_rsp_q.pop_front() : '0;
      n_checks++;
      if (orr !== er) begin n_fail++; $display("FAIL order_rsp: got %h, required %h", orr, er); end
    end
    n_checks++;
    if (obs_issue_q.size() != 0 || obs_rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL order_extra: %0d issues %0d responses left, required 0 0", obs_issue_q.size(), obs_rsp_q.size());
    end
    obs_issue_q.delete(); obs_rsp_q.delete();
  endtask

  task automatic test_reset_mid;
    model_lat = 40; model_rdata = 32'h0F0F0F0F;
    exp_issue_q.push_back(mk_issue(1'b0, 23'h000100, 32'h0, 4'h0));
    push_req(1'b0, 23'h000100, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) push_req(1'b1, 23'h000200 + 23'(k), 32'h1111_0000 + k, 4'h0);
    n_checks++;
    if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL mid_level: level %0d, required 3", fifo_level); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (fifo_level !== 3'd0 || req_ready !== 1'b1 || ctrl_wr_en !== 1'b0 || ctrl_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_now: level %0d ready %b en %b%b, required 0 1 00", fifo_level, req_ready, ctrl_wr_en, ctrl_rd_en);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    while (exp_issue_q.size() > 0) begin
      ei = exp_issue_q.pop_front();
      oi = (obs_issue_q.size() > 0) ? obs_issue_q.pop_front() : '0;
      n_checks++;
      if (oi !== ei) begin n_fail++; $display("FAIL mid_issue: got %h, required %h", oi, ei); end
    end
    n_checks++;
    if (obs_issue_q.size() != 0 || obs_rsp_q.size() != 0 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_after_reset: %0d issues %0d responses level %0d, required 0 0 0",
               obs_issue_q.size(), obs_rsp_q.size(), fifo_level);
    end
    obs_issue_q.delete(); obs_rsp_q.delete();
  endtask

`ifdef SDRAM_REQ_QUEUE_TIMEOUT_EN
  task automatic test_timeout;
    model_lat = 30; model_rdata = 32'h12345678;
    exp_issue_q.push_back(mk_issue(1'b0, 23'h0002AA, 32'h0, 4'h0));
    exp_rsp_q.push_back({1'b1, 32'h0});
    push_req(1'b0, 23'h0002AA, 32'h0, 4'h0);
    @(negedge clk);
    n_checks++;
    if (ctrl_rd_en !== 1'b1) begin n_fail++; $display("FAIL tmo_issue: rd_en %b, required 1", ctrl_rd_en); end
    repeat (16) @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_early: rsp_valid %b at 16, required 0", rsp_valid); end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL tmo_rsp: valid %b err %b rdata %h, required 1 1 0", rsp_valid, rsp_err, rsp_rdata);
    end
    repeat (40) @(negedge clk);
    #1;
    while (exp_issue_q.size() > 0) begin
      ei = exp_issue_q.pop_front();
      oi = (obs_issue_q.size() > 0) ? obs_issue_q.pop_front() : '0;
      n_checks++;
      if (oi !== ei) begin n_fail++; $display("FAIL tmo_issue_sb: got %h, required %h", oi, ei); end
    end
    while (exp_rsp_q.size() > 0) begin
      er = exp_rsp_q.pop_front();
      orr = (obs_rsp_q.size() > 0) ? obs_rsp_q.pop_front() : '0;
      n_checks++;
      if (orr !== er) begin n_fail++; $display("FAIL tmo_rsp_sb: got %h, required %h", orr, er); end
    end
    n_checks++;
    if (obs_issue_q.size() != 0 || obs_rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL tmo_late_ready: %0d issues %0d responses left, required 0 0", obs_issue_q.size(), obs_rsp_q.size());
    end
    obs_issue_q.delete(); obs_rsp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_latency();
    test_back_to_back();
    test_reset_mid();
`ifdef SDRAM_REQ_QUEUE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at 200000 ns, required to finish earlier");
    $fatal(1, "bench did not finish");
  end

endmodule
